// File: rtl/truth_table_capture.sv
// truth_table_capture
//   Response-side companion to the lab's exhaustive gate stimulus. A start
//   request begins a sweep. The block drives every input combination of an
//   N_IN-input combinational DUT and holds each one for DWELL cycles. It
//   samples y at the end of each hold and builds the measured truth table.
//   At the end it compares that table with the expected table that was
//   latched when the sweep started.
//
// Parameters
//   N_IN   number of DUT inputs (sweep covers 2**N_IN vectors), N_IN >= 1
//   DWELL  cycles each vector is held before y is sampled, DWELL >= 1
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   start          begin a sweep (only looked at in IDLE)
//   expected       expected truth table, bit i = expected y for x == i
//   y              DUT output
//   x              DUT input vector
//   busy           high while vectors are being driven and sampled
//   done           one-cycle pulse when results become valid
//   table_out      measured truth table, bit i = sampled y for x == i
//   pass           table_out matches the latched expected table
//   mismatch_count number of differing bits
//
// Optional feature
//   TT_STOP_ON_MISMATCH_EN: when defined, the first mismatching sample ends
//   the sweep. x holds the failing vector through the done cycle.

module truth_table_capture #(
  parameter int N_IN  = 3,
  parameter int DWELL = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 y,
  output logic [N_IN-1:0]      x,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_count
);

  localparam int NV = 2**N_IN;
  // A DWELL of 1 still needs a one-bit counter so the compare stays legal.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
  localparam logic [N_IN-1:0] LAST_X   = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] ONE_X    = 1;
  localparam logic [N_IN:0]   ONE_CNT  = 1;

`ifdef TT_STOP_ON_MISMATCH_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [NV-1:0]   exp_lat;
  logic [NV-1:0]   table_next;
  logic [N_IN:0]   count_next;
  logic            miss;

  // These values would result if y were sampled on this edge. pass is
  // computed from table_next, so the last sample is included even though
  // table_out has not been updated yet.
  always_comb begin
    table_next    = table_out;
    table_next[x] = y;
    miss          = (y != exp_lat[x]);
    count_next    = miss ? (mismatch_count + ONE_CNT) : mismatch_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      exp_lat        <= '0;
      x              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_out      <= '0;
      pass           <= 1'b0;
      mismatch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            exp_lat        <= expected;
            table_out      <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            x              <= '0;
            counter        <= '0;
            busy           <= 1'b1;
            state          <= DRIVE;
          end
        end
        DRIVE: begin
          if (counter == LAST_CNT) begin
            counter        <= '0;
            table_out      <= table_next;
            mismatch_count <= count_next;
            if (x == LAST_X || (STOP_EN && miss)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (table_next == exp_lat);
              state <= FINISH;
            end else begin
              x <= x + ONE_X;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          x     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
